pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
Measures the duration of an externally supplied active-high pulse in the same prescaled tick units the countdown timers use to generate intervals.
- Typical use: read back the exposure or strobe pulse actually seen at a pin, so firmware can check it against the programmed interval.
- Arm, capture one pulse, present the result with a valid/ack handshake, then idle until re-armed.

Parameters:
WIDTH, 16, width of the tick counter and of the elapsed result.
TICK_DIV, 1876, prescaler period in clk cycles per tick (matches the timer tick); must be >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
arm  input  1  single-cycle request: clear and wait for the next rising edge of trig_in.
trig_in  input  1  pulse under measurement; already synchronous to clk.
ack  input  1  consumer acknowledges elapsed; honoured only while valid=1.
elapsed  output  WIDTH  measured width in ticks; stable while valid=1.
valid  output  1  result available; held until ack or arm.
busy  output  1  high in ARMED or RUN.
overflow  output  1  measured width saturated at all-ones; qualified by valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; elapsed=0, valid=0, busy=0, overflow=0.
  - Internal counter, prescaler and trig_in history register all cleared.
- Edge detection:
  - trig_q is trig_in registered once.
  - rise = trig_in & ~trig_q; fall = ~trig_in & trig_q.
  - trig_q resets to 0, so a trig_in already high when leaving reset, or when arm arrives, is not a rise.
- States are IDLE, ARMED, RUN and DONE.
  - IDLE: arm -> ARMED.
  - ARMED: busy=1. rise -> RUN; the rise cycle counts as high cycle 1. A pulse already in progress when armed is ignored; the bench waits for its end and the next rise.
  - RUN: busy=1.
    - Prescaler counts 0..TICK_DIV-1 once per cycle and wraps.
    - Tick counter increments on each wrap, saturating at 2^WIDTH-1; overflow is set on an attempted increment beyond saturation.
    - fall -> DONE; the fall cycle does not count. On that transition: elapsed <= counter, valid <= 1, busy <= 0.
  - DONE: valid=1, busy=0. ack -> IDLE and valid=0; elapsed and overflow hold their values.
- Result requirement:
  - elapsed = min(floor(H / TICK_DIV), 2^WIDTH-1), where H is the number of consecutive clk cycles trig_in is sampled high.
  - Partial ticks truncate.
- Latency: valid rises on the clock edge ending the first low cycle of trig_in, i.e. 1 cycle after the falling edge of trig_in.
- arm in any state:
  - Counter, prescaler and overflow are cleared, valid=0, next state ARMED.
  - A measurement in progress is discarded.
  - arm has priority over simultaneous fall, rise or ack.
- ack outside DONE: ignored.
- ack and arm in the same cycle: arm wins.
- A pulse with H < TICK_DIV gives elapsed=0, valid=1 (a pulse was seen but is shorter than 1 tick).
- Counter width is WIDTH. The prescaler is $clog2(TICK_DIV) bits and compares equal to TICK_DIV-1; it never exceeds that value.

Decomposition:
- Shared package:
  - state enumeration (IDLE/ARMED/RUN/DONE);
  - default TICK_DIV constant (1876), also used by timer instances so both blocks share one tick definition.
- Sub-module tick_prescaler:
  - inputs clk, rst_n and a clear/enable;
  - output is a one-cycle tick pulse every TICK_DIV enabled cycles.
  - Reusable by the countdown timer.
- The measurement FSM, edge detect and saturating counter live in pulse_width_meter.

Test Plan:
- TICK_DIV=4, WIDTH=16: arm, then trig_in high for 40 cycles -> valid rises 1 cycle after trig_in falls; elapsed=10, overflow=0, busy=0.
- TICK_DIV=4: trig_in high for 43 cycles -> elapsed=10 (truncation). High for 3 cycles -> elapsed=0, valid=1.
- TICK_DIV=4, WIDTH=4: trig_in high for 100 cycles -> elapsed=15, overflow=1. Re-arm, then 8 cycles -> elapsed=2, overflow=0.
- trig_in held high before arm, low 5 cycles later, then a 20-cycle pulse -> the first pulse is ignored; elapsed=5 from the second pulse only.
- Handshake:
  - With valid=1, hold ack low for 50 cycles -> elapsed and valid stable throughout.
  - Pulse ack -> valid=0 next cycle, elapsed unchanged.
  - Pulse ack again in IDLE -> no effect.
- Abort and reset cases:
  - arm during RUN, 10 cycles into a pulse -> state ARMED, old pulse discarded, busy stays 1.
  - arm coincident with fall -> no valid.
  - rst_n low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the pulse width meter and the countdown timers.
// - pwm_state_e    : measurement FSM states
// - DefaultTickDiv : clk cycles per tick, common to the meter and the timers
package pulse_width_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRun,
        StDone
    } pwm_state_e;

    localparam int unsigned DefaultTickDiv = 1876;

endpackage

// File: rtl/pulse_width_meter_tick_prescaler.sv
// Tick prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : return the phase counter to 0 (dominates enable)
//   enable : advance the phase counter this cycle
//   tick   : high in the enabled cycle that completes a TICK_DIV period
module pulse_width_meter_tick_prescaler
    import pulse_width_meter_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefaultTickDiv
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign tick = enable & ~clear & (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// Pulse width meter: measures one active-high pulse on trig_in in prescaled ticks.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   arm        : clear and wait for the next rising edge of trig_in
//   trig_in    : pulse under measurement (synchronous to clk)
//   ack        : consumer acknowledge, honoured only while valid
//   elapsed    : measured width in ticks, saturating
//   valid      : result available until ack or arm
//   busy       : waiting for or measuring a pulse
//   overflow   : width saturated at all-ones (qualified by valid)
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TICK_DIV = DefaultTickDiv
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             trig_in,
    input  logic             ack,
    output logic [WIDTH-1:0] elapsed,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CntSat = '1;

    pwm_state_e       state_q, state_d;
    logic             trig_q;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] elapsed_q, elapsed_d;
    logic             overflow_q, overflow_d;
    logic             rise, fall;
    logic             presc_en, tick;

    assign rise = trig_in & ~trig_q;
    assign fall = ~trig_in & trig_q;

    // The rise cycle is the first high cycle; the fall cycle is not counted.
    assign presc_en = ~arm & (((state_q == StArmed) & rise) | ((state_q == StRun) & ~fall));

    pulse_width_meter_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (arm),
        .enable (presc_en),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; arm overrides every other event
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = StArmed;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StArmed: if (rise) state_d = StRun;
                StRun:   if (fall) state_d = StDone;
                StDone:  if (ack)  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (state_q)
            StArmed, StRun: busy  = 1'b1;
            StDone:         valid = 1'b1;
            default:        ;
        endcase
    end

    // Saturating tick counter and result capture
    always_comb begin
        counter_d  = counter_q;
        overflow_d = overflow_q;
        elapsed_d  = elapsed_q;
        if (arm) begin
            counter_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (tick) begin
                if (counter_q == CntSat) begin
                    overflow_d = 1'b1;
                end else begin
                    counter_d = counter_q + WIDTH'(1);
                end
            end
            if ((state_q == StRun) && fall) begin
                elapsed_d = counter_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q     <= 1'b0;
            counter_q  <= '0;
            elapsed_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            trig_q     <= trig_in;
            counter_q  <= counter_d;
            elapsed_q  <= elapsed_d;
            overflow_q <= overflow_d;
        end
    end

    assign elapsed  = elapsed_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: two instances (WIDTH 16 and 4, TICK_DIV 4) share stimulus;
// expected results come from min(floor(H / TICK_DIV), 2^WIDTH - 1).
module tb_pulse_width_meter;

    localparam int unsigned TickDiv = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        trig_in;
    logic        ack;
    logic [15:0] elapsed16;
    logic        valid16, busy16, overflow16;
    logic [3:0]  elapsed4;
    logic        valid4, busy4, overflow4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_width_meter #(
        .WIDTH    (16),
        .TICK_DIV (TickDiv)
    ) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .trig_in  (trig_in),
        .ack      (ack),
        .elapsed  (elapsed16),
        .valid    (valid16),
        .busy     (busy16),
        .overflow (overflow16)
    );

    pulse_width_meter #(
        .WIDTH    (4),
        .TICK_DIV (TickDiv)
    ) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .trig_in  (trig_in),
        .ack      (ack),
        .elapsed  (elapsed4),
        .valid    (valid4),
        .busy     (busy4),
        .overflow (overflow4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled on that edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_elapsed(input int h, input int w);
        int t;
        int sat;
        t   = h / TickDiv;
        sat = (1 << w) - 1;
        return (t > sat) ? sat : t;
    endfunction

    function automatic int model_overflow(input int h, input int w);
        return ((h / TickDiv) > ((1 << w) - 1)) ? 1 : 0;
    endfunction

    // Arm, wait gap cycles, drive an h-cycle pulse and check the result.
    task automatic run_pulse(input int h, input int gap);
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check_eq("armed_busy", busy16, 1);
        check_eq("armed_valid", valid16, 0);
        repeat (gap) cycle();
        trig_in = 1'b1;
        repeat (h) cycle();
        trig_in = 1'b0;
        check_eq("valid_before_low_cycle", valid16, 0);
        cycle();
        check_eq("valid_after_fall", valid16, 1);
        check_eq("busy_done", busy16, 0);
        check_eq("elapsed16", elapsed16, model_elapsed(h, 16));
        check_eq("overflow16", overflow16, model_overflow(h, 16));
        check_eq("elapsed4", elapsed4, model_elapsed(h, 4));
        check_eq("overflow4", overflow4, model_overflow(h, 4));
        check_eq("valid4", valid4, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_elapsed16"}, elapsed16, 0);
        check_eq({tag, "_valid16"}, valid16, 0);
        check_eq({tag, "_busy16"}, busy16, 0);
        check_eq({tag, "_overflow16"}, overflow16, 0);
        check_eq({tag, "_elapsed4"}, elapsed4, 0);
        check_eq({tag, "_busy4"}, busy4, 0);
    endtask

    initial begin
        int h;
        int gap;
        rst_n   = 1'b0;
        arm     = 1'b0;
        trig_in = 1'b0;
        ack     = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check_outputs_zero("idle");

        // Nominal 40-cycle pulse, then the handshake
        run_pulse(40, 2);
        repeat (50) begin
            cycle();
            check_eq("hold_valid", valid16, 1);
            check_eq("hold_elapsed", elapsed16, 10);
        end
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        check_eq("ack_valid", valid16, 0);
        check_eq("ack_elapsed", elapsed16, 10);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        cycle();
        check_eq("idle_ack_valid", valid16, 0);
        check_eq("idle_ack_busy", busy16, 0);
        check_eq("idle_ack_elapsed", elapsed16, 10);

        // Truncation, sub-tick pulse, saturation and recovery
        run_pulse(43, 0);
        run_pulse(3, 1);
        run_pulse(100, 2);
        run_pulse(8, 1);

        // Pulse already high when armed is ignored
        trig_in = 1'b1;
        repeat (3) cycle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        repeat (4) cycle();
        trig_in = 1'b0;
        cycle();
        check_eq("prehigh_valid", valid16, 0);
        check_eq("prehigh_busy", busy16, 1);
        repeat (2) cycle();
        trig_in = 1'b1;
        repeat (20) cycle();
        trig_in = 1'b0;
        cycle();
        check_eq("prehigh_second_valid", valid16, 1);
        check_eq("prehigh_second_elapsed", elapsed16, 5);

        // Arm mid-pulse discards the measurement
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        trig_in = 1'b1;
        repeat (10) cycle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check_eq("rearm_busy", busy16, 1);
        check_eq("rearm_valid", valid16, 0);
        repeat (6) cycle();
        trig_in = 1'b0;
        repeat (2) cycle();
        check_eq("rearm_old_fall_valid", valid16, 0);
        check_eq("rearm_old_fall_busy", busy16, 1);
        trig_in = 1'b1;
        repeat (12) cycle();
        trig_in = 1'b0;
        cycle();
        check_eq("rearm_new_valid", valid16, 1);
        check_eq("rearm_new_elapsed", elapsed16, 3);

        // Arm coincident with the fall: no result
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        trig_in = 1'b1;
        repeat (9) cycle();
        trig_in = 1'b0;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        repeat (3) cycle();
        check_eq("arm_fall_valid", valid16, 0);
        check_eq("arm_fall_busy", busy16, 1);

        // Randomized pulses against the model
        for (int i = 0; i < 20; i++) begin
            h   = int'($urandom_range(1, 90));
            gap = int'($urandom_range(0, 4));
            run_pulse(h, gap);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) cycle();
                ack = 1'b1;
                cycle();
                ack = 1'b0;
                check_eq("rand_ack_valid", valid16, 0);
                check_eq("rand_ack_elapsed", elapsed16, model_elapsed(h, 16));
            end
        end

        // Asynchronous reset mid-measurement
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        trig_in = 1'b1;
        repeat (10) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        trig_in = 1'b0;
        rst_n = 1'b1;
        cycle();
        check_outputs_zero("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
